// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD scheduler: FSM state encoding,
// default widths and the requester-index width helper.
package gcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int GCD_W     = 32;
   localparam int GCD_N_REQ = 4;

   // A single requester still needs a 1-bit index so ports never collapse to zero width.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gcd_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester found at or
// above ptr, wrapping around to index 0.
module gcd_rr_arb #(
   parameter int N_REQ = 4,
   parameter int PW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt
);

   int   idx;
   logic found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gcd_sched.sv
// Shared subtractive-GCD engine: round-robin grant among N_REQ requesters,
// one subtract per RUN cycle, result held in DONE until consumed.
module gcd_sched
   import gcd_pkg::*;
#(
   parameter int W        = GCD_W,
   parameter int N_REQ    = GCD_N_REQ,
   parameter int ITER_MAX = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*W-1:0]      req_a,
   input  logic [N_REQ*W-1:0]      req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [W-1:0]            rsp_gcd,
   output logic [id_w(N_REQ)-1:0]  rsp_id,
   output logic                    rsp_err,
   output logic                    busy
);

   localparam int IDW = id_w(N_REQ);
   localparam int ITW = $clog2(ITER_MAX) + 1;

   state_e           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   run_id_q, run_id_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [W-1:0]     x_q, x_d, y_q, y_d;
   logic [W-1:0]     gcd_q, gcd_d;
   logic [ITW-1:0]   iter_q, iter_d;
   logic             err_q, err_d;

   logic [N_REQ-1:0] gnt;
   logic [IDW-1:0]   gnt_id;
   logic [W-1:0]     a_sel, b_sel, hi, lo;

   gcd_rr_arb #(
      .N_REQ (N_REQ),
      .PW    (IDW)
   ) u_arb (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (gnt)
   );

   always_comb begin
      gnt_id = '0;
      a_sel  = '0;
      b_sel  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            gnt_id = IDW'(i);
            a_sel  = req_a[i*W +: W];
            b_sel  = req_b[i*W +: W];
         end
      end
   end

   assign hi = (x_q >= y_q) ? x_q : y_q;
   assign lo = (x_q >= y_q) ? y_q : x_q;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      run_id_d = run_id_q;
      rsp_id_d = rsp_id_q;
      x_d      = x_q;
      y_d      = y_q;
      gcd_d    = gcd_q;
      iter_d   = iter_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (|gnt) begin
               x_d      = a_sel;
               y_d      = b_sel;
               run_id_d = gnt_id;
               iter_d   = '0;
               ptr_d    = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            // Result fields change only on entry to DONE so they hold between responses.
            if (lo == '0) begin
               gcd_d    = hi;
               err_d    = 1'b0;
               rsp_id_d = run_id_q;
               state_d  = DONE;
            end else if (iter_q == ITW'(ITER_MAX - 1)) begin
               gcd_d    = '0;
               err_d    = 1'b1;
               rsp_id_d = run_id_q;
               state_d  = DONE;
            end else begin
               x_d    = hi - lo;
               y_d    = lo;
               iter_d = iter_q + 1'b1;
            end
         end
         DONE: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         run_id_q <= '0;
         rsp_id_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         gcd_q    <= '0;
         iter_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         run_id_q <= run_id_d;
         rsp_id_q <= rsp_id_d;
         x_q      <= x_d;
         y_q      <= y_d;
         gcd_q    <= gcd_d;
         iter_q   <= iter_d;
         err_q    <= err_d;
      end
   end

   assign req_ready = (state_q == IDLE) ? gnt : '0;
   assign rsp_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign rsp_gcd   = gcd_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched: expected responses are queued as requests are
// issued and matched, with latency, when each response first appears.
module tb_gcd_sched;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   req_valid = '0;
   logic [3:0]   req_ready;
   logic [127:0] req_a = '0;
   logic [127:0] req_b = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic [31:0]  rsp_gcd;
   logic [1:0]   rsp_id;
   logic         rsp_err;
   logic         busy;

   typedef struct {
      logic [31:0] gcd;
      logic [1:0]  id;
      logic        err;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   t_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   bit   prev_v = 1'b0;

   gcd_sched #(.W(32), .N_REQ(4), .ITER_MAX(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_gcd   (rsp_gcd),
      .rsp_id    (rsp_id),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: grant order against the queue head, response content and latency.
   always @(negedge clk) begin
      exp_t       e;
      int         t;
      logic [3:0] oh;
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         if (|(req_valid & req_ready)) begin
            if (exp_q.size() == 0) begin
               chk("unexp_grant", {60'd0, req_ready}, 64'd0);
            end else begin
               oh = 4'b0001 << exp_q[0].id;
               chk("grant", {60'd0, req_ready}, {60'd0, oh});
            end
            t_q.push_back(cyc + 1);
         end
         if (rsp_valid && !prev_v) begin
            if (exp_q.size() == 0 || t_q.size() == 0) begin
               chk("unexp_rsp", {63'd0, rsp_valid}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               t = t_q.pop_front();
               chk("rsp_gcd", {32'd0, rsp_gcd}, {32'd0, e.gcd});
               chk("rsp_id", {62'd0, rsp_id}, {62'd0, e.id});
               chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
               if (e.lat > 0) chk("latency", 64'(cyc), 64'(t + e.lat));
            end
         end
         prev_v = rsp_valid;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
   endtask

   task automatic push(input int i, input logic [31:0] g, input bit e, input int lat);
      exp_t x;
      x.gcd = g;
      x.id  = 2'(i);
      x.err = e;
      x.lat = lat;
      exp_q.push_back(x);
   endtask

   // Raise one requester, hold until granted, drop right after the handshake edge.
   task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] g, input bit e, input int lat);
      int n = 0;
      set_ops(i, a, b);
      push(i, g, e, lat);
      req_valid[i] = 1'b1;
      #1;
      while (!req_ready[i] && n < 20) begin
         step();
         n++;
      end
      if (!req_ready[i]) chk("grant_timeout", {63'd0, req_ready[i]}, 64'd1);
      step();
      req_valid[i] = 1'b0;
   endtask

   task automatic drain(input int max);
      int n = 0;
      while (exp_q.size() != 0 && n < max) begin
         step();
         n++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      step();
      step();
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
      rst = 1'b0;
      step();
      chk("post_rst_busy", {63'd0, busy}, 64'd0);
      chk("post_rst_gcd", {32'd0, rsp_gcd}, 64'd0);
      chk("post_rst_id", {62'd0, rsp_id}, 64'd0);
      chk("post_rst_err", {63'd0, rsp_err}, 64'd0);

      // Single request on requester 0
      issue(0, 32'd12, 32'd8, 32'd4, 1'b0, 4);
      drain(30);
      step();
      chk("idle_hold_gcd", {32'd0, rsp_gcd}, 64'd4);
      chk("idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);

      // Zero operands, one RUN cycle each
      issue(1, 32'd0, 32'd0, 32'd0, 1'b0, 1);
      drain(30);
      issue(2, 32'd7, 32'd0, 32'd7, 1'b0, 1);
      drain(30);
      issue(3, 32'd0, 32'd9, 32'd9, 1'b0, 1);
      drain(30);

      // All requesters held: grant order 0,1,2,3,0
      set_ops(0, 32'd12, 32'd8);
      set_ops(1, 32'd0, 32'd9);
      set_ops(2, 32'd7, 32'd0);
      set_ops(3, 32'd48, 32'd18);
      push(0, 32'd4, 1'b0, 4);
      push(1, 32'd9, 1'b0, 1);
      push(2, 32'd7, 1'b0, 1);
      push(3, 32'd6, 1'b0, 6);
      push(0, 32'd4, 1'b0, 4);
      req_valid = 4'b1111;
      drain(200);
      req_valid = 4'b0000;
      step();

      // Iteration limit
      issue(2, 32'd1, 32'd100, 32'd0, 1'b1, 64);
      drain(120);
      step();

      // Backpressure in DONE with another requester waiting
      rsp_ready = 1'b0;
      issue(1, 32'd12, 32'd8, 32'd4, 1'b0, 4);
      for (int n = 0; n < 20 && !rsp_valid; n++) step();
      chk("bp_reach_done", {63'd0, rsp_valid}, 64'd1);
      set_ops(3, 32'd0, 32'd9);
      push(3, 32'd9, 1'b0, 1);
      req_valid[3] = 1'b1;
      for (int n = 0; n < 5; n++) begin
         step();
         chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
         chk("bp_gcd", {32'd0, rsp_gcd}, 64'd4);
         chk("bp_id", {62'd0, rsp_id}, 64'd1);
         chk("bp_req_ready", {60'd0, req_ready}, 64'd0);
      end
      rsp_ready = 1'b1;
      step();
      chk("bp_release_busy", {63'd0, busy}, 64'd0);
      chk("bp_release_valid", {63'd0, rsp_valid}, 64'd0);
      chk("bp_release_ready", {60'd0, req_ready}, 64'h8);
      step();
      req_valid[3] = 1'b0;
      drain(30);
      step();

      // Reset mid-RUN aborts silently
      issue(0, 32'd48, 32'd18, 32'd6, 1'b0, 6);
      chk("mid_run_busy", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
      t_q.delete();
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_gcd", {32'd0, rsp_gcd}, 64'd0);
      for (int n = 0; n < 8; n++) begin
         step();
         chk("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
      end
      issue(0, 32'd48, 32'd18, 32'd6, 1'b0, 6);
      drain(30);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gcd_sched.md
GCD_SCHED -- requirements
Module: gcd_sched

Interface
REQ-001 SHALL expose parameter W, default 32: operand and result width.
REQ-002 SHALL expose parameter N_REQ, default 4: number of requesters.
REQ-003 SHALL expose parameter ITER_MAX, default 64: maximum RUN cycles before abort.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, N_REQ bits: per-requester request.
REQ-007 SHALL have port req_ready, output, N_REQ bits: per-requester accept, at most one bit set.
REQ-008 SHALL have port req_a, input, N_REQ*W bits: operand a, requester i in slice [i*W +: W].
REQ-009 SHALL have port req_b, input, N_REQ*W bits: operand b, same slicing.
REQ-010 SHALL have port rsp_valid, output, 1 bit: result available.
REQ-011 SHALL have port rsp_ready, input, 1 bit: consumer accepts result.
REQ-012 SHALL have port rsp_gcd, output, W bits: result.
REQ-013 SHALL have port rsp_id, output, clog2(N_REQ) bits: requester index of the result.
REQ-014 SHALL have port rsp_err, output, 1 bit: iteration limit hit, so rsp_gcd is invalid.
REQ-015 SHALL have port busy, output, 1 bit: high when not in IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-017 IDLE SHALL drive req_ready as the round-robin grant over req_valid, combinationally; req_ready SHALL be all zero in RUN and DONE.
REQ-018 Handshake SHALL be req_valid[i] & req_ready[i] in IDLE; on that edge x<=a_i, y<=b_i, id<=i, iter<=0, state<=RUN.
REQ-019 Round-robin pointer SHALL reset to 0 and, after a grant to i, become (i+1) mod N_REQ; search starts at the pointer and proceeds upward with wrap.
REQ-020 In each RUN cycle, hi=max(x,y) and lo=min(x,y), unsigned; if lo==0, result<=hi, err<=0, state<=DONE; else x<=hi-lo, y<=lo, iter<=iter+1.
REQ-021 If lo!=0 and iter==ITER_MAX-1 in RUN, the block SHALL go to DONE with result<=0 and err<=1.
REQ-022 Latency: with handshake at edge T and N RUN cycles, rsp_valid SHALL first be high in cycle T+N; N>=1.
REQ-023 DONE SHALL hold rsp_valid=1 and rsp_gcd/rsp_id/rsp_err stable until rsp_valid&rsp_ready, then go to IDLE; the next grant is possible no earlier than the following cycle.
REQ-024 Outside DONE, rsp_valid SHALL be 0; rsp_gcd, rsp_id and rsp_err SHALL hold their last values.
REQ-025 Boundary results: gcd(0,0)=0, gcd(a,0)=a, gcd(0,b)=b, each with N=1.
REQ-026 req_valid changes during RUN or DONE SHALL be ignored; a requester keeps req_valid high until it is granted.

Reset
REQ-027 With rst high at an edge, state<=IDLE, rr pointer<=0, x<=0, y<=0, iter<=0, rsp_gcd<=0, rsp_id<=0, rsp_err<=0.
REQ-028 After reset, rsp_valid=0, busy=0, req_ready=0 until the first IDLE evaluation with req_valid set.
REQ-029 Reset during RUN or DONE SHALL abort the operation with no response.

Structure
REQ-030 Package gcd_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default W and N_REQ constants.
REQ-031 Sub-module gcd_rr_arb (inputs req and pointer; output one-hot grant) SHALL be the only sub-module.
REQ-032 Compare and subtract SHALL be inline, one subtract per cycle.

Verification
REQ-033 Single request, requester 0, a=12, b=8 -> rsp_valid at T+4, rsp_gcd=4, rsp_id=0, rsp_err=0.
REQ-034 req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_id matches the grant.
REQ-035 Zero operands: (0,0) -> 0; (7,0) -> 7; (0,9) -> 9; each with rsp_valid at T+1.
REQ-036 Requester 2, a=1, b=100, ITER_MAX=64 -> DONE at T+64 with rsp_err=1, rsp_gcd=0, rsp_id=2.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles in DONE -> outputs stable, req_ready=0; release -> IDLE next cycle.
REQ-038 rst asserted for one cycle mid-RUN of (48,18) -> no rsp_valid, busy=0, a new (48,18) request afterwards -> 6.
